mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency 16-bit memory between the instruction-fetch port (I) and the data load/store port (D) of the single-cycle→multicycle CPU.
- Sits between PC/fetch logic and LW/SW datapath on one side and the memory instance on the other.
- Round-robin arbitration under contention; FSM sequences issue, latency wait, and response.
- Strict valid/done handshake; the memory's latency is checked, not trusted.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 4, cycles from the issue cycle to the expected mem_data_valid (legal range ≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- i_req  in  1  instruction read request; held until i_done
- i_addr  in  ADDR_W  fetch address; stable while i_req high
- i_rdata  out  DATA_W  fetched word; valid when i_done=1
- i_done  out  1  one-cycle completion pulse, I port
- d_req  in  1  data request; held until d_done
- d_wr  in  1  1=write (SW), 0=read (LW); stable while d_req high
- d_addr  in  ADDR_W  data address; stable while d_req high
- d_wdata  in  DATA_W  store data; stable while d_req high
- d_rdata  out  DATA_W  load data; valid when d_done=1
- d_done  out  1  one-cycle completion pulse, D port
- mem_enable  out  1  memory access strobe, high only in ISSUE
- mem_wr  out  1  memory write enable, high only in ISSUE of a write
- mem_addr  out  ADDR_W  latched access address
- mem_data_in  out  DATA_W  latched write data
- mem_data_out  in  DATA_W  memory read data
- mem_data_valid  in  1  memory read data valid
- busy  out  1  high in any state other than IDLE
- grant  out  1  owner of the current/last transaction: 0=I, 1=D
- mem_err  out  1  sticky latency-violation flag

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (async, any state, including mid-transaction):
  - state=IDLE; all outputs 0 (rdata regs 0, mem_err 0, grant 0).
  - last_grant=0 (I), so the first contention goes to D.
  - Any in-flight access is abandoned; a late mem_data_valid is ignored.
- IDLE:
  - If only one req is high, grant it. If both are high, grant the port not equal to last_grant. If neither, stay.
  - On grant: latch addr, wdata, and wr (I forces wr=0); update grant and last_grant → ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_enable=1; mem_wr=latched wr; mem_addr and mem_data_in driven from the latches.
  - Write → RESP. Read → WAIT with cnt=1.
- WAIT:
  - cnt increments each cycle.
  - mem_data_valid while cnt<MEM_LAT: ignored, sets mem_err.
  - At cnt==MEM_LAT: capture mem_data_out into the granted port's rdata register → RESP.
  - If mem_data_valid is low at that point, set mem_err and capture anyway; no hang.
  - The counter saturates; it never wraps.
- RESP (1 cycle): assert done of the granted port only → IDLE.
- Latency:
  - Read: req sampled in IDLE at cycle t → ISSUE t+1 → data at t+1+MEM_LAT → done at t+2+MEM_LAT (cycle 6 for MEM_LAT=4).
  - Write: done at t+2; the memory write occurs at the ISSUE edge.
- Handshake:
  - Requester drops req at the edge where it samples done. A req still high in the following IDLE cycle is a new request.
  - The non-granted req stays pending, unaffected, and is served next.
- Data holding:
  - i_rdata/d_rdata hold the last read value until the next read on that port; they are not cleared by writes.
  - The other port's rdata is never disturbed.
- mem_err clears only on rst.
- Max throughput: one access per 3 cycles (write) or MEM_LAT+3 cycles (read).
- No combinational path from req to mem_* outputs.

Test Plan:
- I-only read, i_addr=0x0010, mem returns 0xA5A5 with valid at ISSUE+4 → i_done pulses exactly at cycle t+6, i_rdata=0xA5A5, d_done stays 0, mem_err=0.
- D write, d_addr=0x0200, d_wdata=0x1234 → mem_enable=mem_wr=1 for one cycle with those values; d_done at t+2; no I activity.
- After reset, i_req and d_req asserted together and held → D served first (grant=1), then I. Both re-asserted immediately: order D, I, D, I; no starvation.
- D read in progress with i_req raised mid-WAIT → I waits; d_rdata correct; I issues the cycle after D's RESP→IDLE; i_rdata untouched by the D read.
- rst pulsed in WAIT (cnt=2), followed by late mem_data_valid → state IDLE, outputs 0, no done pulse, mem_err=0.
- Memory model asserts valid at ISSUE+2 and not at ISSUE+4 → mem_err=1 and sticky, d_done still at t+6; mem_err cleared only by rst.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-ported, fixed-latency memory between an
//               instruction-fetch port (I, read only) and a data load/store
//               port (D). Round-robin arbitration under contention; a
//               four-state FSM sequences issue, latency wait and response.
//               The memory's read latency is checked: an early or missing
//               mem_data_valid raises the sticky mem_err flag.
// Ports       : clk, rst            - clock, async active-high reset
//               i_req/i_addr        - fetch request and address
//               i_rdata/i_done      - fetched word, completion pulse
//               d_req/d_wr/d_addr/d_wdata - load/store request
//               d_rdata/d_done      - load data, completion pulse
//               mem_*               - memory-side strobe, address, data
//               busy, grant, mem_err - status
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_data_valid,
    output logic              busy,
    output logic              grant,
    output logic              mem_err
);

    localparam int                 c_CNT_W = $clog2(MEM_LAT + 1);
    localparam logic [c_CNT_W-1:0] c_LAT   = c_CNT_W'(MEM_LAT);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_take;
    logic                w_pick_d;

    // r_grant doubles as the round-robin "last grant": both are updated on
    // every grant and reset to I, so a separate register would only mirror it.
    logic                r_grant;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_err;

    // ------------------------------------------------------------------------
    // Next-state and arbitration decision
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_pick_d     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req || d_req) begin
                    w_take       = 1'b1;
                    // Under contention serve the port that did not win last.
                    w_pick_d     = d_req && (!i_req || !r_grant);
                    w_next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_next_state = r_wr ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                // Leave at the expected latency whether or not data showed
                // up, so a silent memory cannot hang the CPU.
                if (r_cnt == c_LAT) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Request latches, latency counter, read-data capture, error flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant   <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_grant <= w_pick_d;
                        r_wr    <= w_pick_d && d_wr;
                        r_addr  <= w_pick_d ? d_addr  : i_addr;
                        r_wdata <= w_pick_d ? d_wdata : '0;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= c_ONE;
                end
                S_WAIT: begin
                    if (r_cnt == c_LAT) begin
                        if (r_grant) begin
                            r_d_rdata <= mem_data_out;
                        end else begin
                            r_i_rdata <= mem_data_out;
                        end
                        if (!mem_data_valid) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        // Saturating count; an early valid is a violation.
                        r_cnt <= r_cnt + c_ONE;
                        if (mem_data_valid) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state only, no path from req
    // ------------------------------------------------------------------------
    assign mem_enable  = (r_state == S_ISSUE);
    assign mem_wr      = (r_state == S_ISSUE) && r_wr;
    assign mem_addr    = r_addr;
    assign mem_data_in = r_wdata;
    assign i_done      = (r_state == S_RESP) && !r_grant;
    assign d_done      = (r_state == S_RESP) &&  r_grant;
    assign i_rdata     = r_i_rdata;
    assign d_rdata     = r_d_rdata;
    assign busy        = (r_state != S_IDLE);
    assign grant       = r_grant;
    assign mem_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. A behavioural memory
//               model answers reads after a configurable delay; a
//               transaction-level reference predicts service order, done
//               cycles and read data from the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic [15:0] i_rdata;
    logic        i_done;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        mem_enable;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic        mem_data_valid;
    logic        busy;
    logic        grant;
    logic        mem_err;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_data_valid(mem_data_valid),
        .busy(busy), .grant(grant), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int idx);
        if (idx == 16'h10) return 16'hA5A5;
        return 16'(idx * 16'h0101) ^ 16'h3C5A;
    endfunction

    // ---------------- memory model ----------------
    int          cyc = 0;
    logic [15:0] mem_arr [256];
    bit          mem_wrt [256];
    bit          pend = 1'b0;
    int          iss_cyc = 0;
    logic [15:0] pend_data = '0;
    int          lat_cfg = L;
    int          early_cfg = 0;
    bit          norm_en = 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_enable) begin
            if (mem_wr) begin
                mem_arr[mem_addr[7:0]] <= mem_data_in;
                mem_wrt[mem_addr[7:0]] <= 1'b1;
            end else begin
                pend      <= 1'b1;
                iss_cyc   <= cyc;
                pend_data <= mem_wrt[mem_addr[7:0]] ? mem_arr[mem_addr[7:0]]
                                                    : init_val(int'(mem_addr[7:0]));
            end
        end
    end

    assign mem_data_out   = pend_data;
    assign mem_data_valid = pend && ((norm_en && (cyc == iss_cyc + lat_cfg)) ||
                                     ((early_cfg != 0) && (cyc == iss_cyc + early_cfg)));

    // ---------------- issue monitor ----------------
    int          n_iss = 0;
    logic [15:0] iss_addr = '0;
    logic [15:0] iss_data = '0;
    logic        iss_wr = 1'b0;

    always @(negedge clk) begin
        if (mem_enable) begin
            n_iss    <= n_iss + 1;
            iss_addr <= mem_addr;
            iss_data <= mem_data_in;
            iss_wr   <= mem_wr;
        end
    end

    // ---------------- reference state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] shadow [256];
    bit          m_last = 1'b0;
    logic [15:0] m_i_rdata = '0;
    logic [15:0] m_d_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_req = 1'b0;
        d_req = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_last    = 1'b0;
        m_i_rdata = '0;
        m_d_rdata = '0;
    endtask

    // One round: each enabled port raises its request at its offset (cycles
    // from round start) and holds it until its done. Called with the arbiter
    // idle, at posedge+1.
    task automatic do_round(input bit ien, input int ioff, input logic [15:0] ia,
                            input bit den, input int doff, input bit dw,
                            input logic [15:0] da, input logic [15:0] dwd,
                            input bit exp_err, input string tag);
        int t0, ti, td, now, free, exp_i, exp_d, got_i, got_d, ni, nd, iss0;
        bit si, sd, ci, cd, pk_d, fi, fd;
        t0 = cyc; ti = t0 + ioff; td = t0 + doff;
        si = !ien; sd = !den; free = t0; exp_i = -1; exp_d = -1;
        // Reference: serve ports in arbitration order, one access at a time.
        repeat (2) begin
            if (!(si && sd)) begin
                if (!si && !sd) now = (ti < td) ? ti : td;
                else if (!si)   now = ti;
                else            now = td;
                if (now < free) now = free;
                ci = !si && (ti <= now);
                cd = !sd && (td <= now);
                pk_d = cd && (!ci || !m_last);
                if (pk_d) begin
                    exp_d = now + (dw ? 2 : 2 + L);
                    sd = 1'b1; m_last = 1'b1;
                    if (dw) shadow[da[7:0]] = dwd;
                    else    m_d_rdata = shadow[da[7:0]];
                    free = exp_d + 1;
                end else begin
                    exp_i = now + 2 + L;
                    si = 1'b1; m_last = 1'b0;
                    m_i_rdata = shadow[ia[7:0]];
                    free = exp_i + 1;
                end
            end
        end
        iss0 = n_iss; got_i = -1; got_d = -1; ni = 0; nd = 0;
        for (int k = 0; k < 100; k++) begin
            if (ien && k == ioff) begin i_req = 1'b1; i_addr = ia; end
            if (den && k == doff) begin
                d_req = 1'b1; d_wr = dw; d_addr = da; d_wdata = dwd;
            end
            @(negedge clk);
            fi = i_done; fd = d_done;
            if (fi) begin
                ni++; got_i = cyc;
                chk({tag, "/i_rdata@done"}, 32'(i_rdata), 32'(m_i_rdata));
            end
            if (fd) begin
                nd++; got_d = cyc;
                if (!dw) chk({tag, "/d_rdata@done"}, 32'(d_rdata), 32'(m_d_rdata));
            end
            @(posedge clk);
            #1;
            if (fi) i_req = 1'b0;
            if (fd) d_req = 1'b0;
            if ((!ien || ni > 0) && (!den || nd > 0)) break;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        chk({tag, "/i_done_cycle"}, 32'(got_i), 32'(exp_i));
        chk({tag, "/d_done_cycle"}, 32'(got_d), 32'(exp_d));
        chk({tag, "/i_done_pulses"}, 32'(ni), 32'(ien ? 1 : 0));
        chk({tag, "/d_done_pulses"}, 32'(nd), 32'(den ? 1 : 0));
        chk({tag, "/issues"}, 32'(n_iss - iss0), 32'(int'(ien) + int'(den)));
        chk({tag, "/grant"}, 32'(grant), 32'(m_last));
        chk({tag, "/mem_err"}, 32'(mem_err), 32'(exp_err));
        chk({tag, "/i_rdata_hold"}, 32'(i_rdata), 32'(m_i_rdata));
        chk({tag, "/d_rdata_hold"}, 32'(d_rdata), 32'(m_d_rdata));
    endtask

    initial begin
        int sel;
        int ndone;
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst/ctrl", 32'({i_done, d_done, mem_enable, mem_wr, busy, grant, mem_err}), 32'd0);
        chk("rst/i_rdata", 32'(i_rdata), 32'd0);
        chk("rst/d_rdata", 32'(d_rdata), 32'd0);
        chk("rst/mem_addr", 32'(mem_addr), 32'd0);
        chk("rst/mem_data_in", 32'(mem_data_in), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // I-only read
        do_round(1'b1, 0, 16'h0010, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0, "i_read");
        chk("i_read/value", 32'(i_rdata), 32'h0000A5A5);

        // D-only write
        do_round(1'b0, 0, 16'h0, 1'b1, 0, 1'b1, 16'h0200, 16'h1234, 1'b0, "d_write");
        chk("d_write/iss_addr", 32'(iss_addr), 32'h0200);
        chk("d_write/iss_data", 32'(iss_data), 32'h1234);
        chk("d_write/iss_wr", 32'(iss_wr), 32'd1);

        // Contention after reset: D, I, then D, I again
        do_reset();
        do_round(1'b1, 0, 16'h0003, 1'b1, 0, 1'b0, 16'h0004, 16'h0, 1'b0, "contend1");
        do_round(1'b1, 0, 16'h0006, 1'b1, 0, 1'b1, 16'h0003, 16'hBEEF, 1'b0, "contend2");
        chk("contend2/last_grant_is_i", 32'(grant), 32'd0);

        // D read with I raised mid-WAIT
        do_round(1'b1, 3, 16'h0003, 1'b1, 0, 1'b0, 16'h0009, 16'h0, 1'b0, "d_then_i");

        // Reset in WAIT (cnt=2) followed by a late valid
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0005;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; d_req = 1'b0;
        #2 rst = 1'b0;
        m_last = 1'b0; m_i_rdata = '0; m_d_rdata = '0;
        @(negedge clk);
        chk("rst_wait/ctrl", 32'({busy, grant, mem_enable, mem_err}), 32'd0);
        chk("rst_wait/d_rdata", 32'(d_rdata), 32'd0);
        chk("rst_wait/i_rdata", 32'(i_rdata), 32'd0);
        chk("rst_wait/mem_addr", 32'(mem_addr), 32'd0);
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (i_done || d_done || busy) ndone++;
        end
        chk("rst_wait/no_activity", 32'(ndone), 32'd0);
        chk("rst_wait/mem_err", 32'(mem_err), 32'd0);
        @(posedge clk);
        #1;

        // Randomized rounds
        for (int r = 0; r < 30; r++) begin
            sel = int'($urandom_range(1, 3));
            do_round(sel[0], int'($urandom_range(0, 6)), 16'($urandom_range(0, 15)),
                     sel[1], int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                     16'($urandom_range(0, 15)), 16'($urandom), 1'b0, "rnd");
        end

        // Latency violation: early valid at ISSUE+2, none at ISSUE+4
        norm_en = 1'b0; early_cfg = 2;
        do_round(1'b0, 0, 16'h0, 1'b1, 0, 1'b0, 16'h0007, 16'h0, 1'b1, "lat_err");
        norm_en = 1'b1; early_cfg = 0;
        do_round(1'b1, 0, 16'h0008, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b1, "err_sticky");
        do_reset();
        @(negedge clk);
        chk("err_cleared", 32'(mem_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
